// File: rtl/soc_dma_entry_scheduler.sv
// soc_dma_entry_scheduler: round-robin arbiter that shares one DMA transfer engine among the request-table entries.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              global enable; 0 blocks new grants (an entry in flight still completes)
//   entry_valid[N]      pending request-table entries
//   grant_valid/idx     entry offered to the engine (idx also names the active entry)
//   grant_ready         engine accepts the offered entry
//   engine_done         engine finished the active entry (pulse)
//   entry_clear[N]      one-hot pulse that clears the completed entry
//   timeout             pulse with entry_clear when the watchdog forced completion
//   irq[N] / irq_ack[N] sticky completion flags and their clear strobes
//   busy                high whenever the FSM is not idle
module soc_dma_entry_scheduler #(
  parameter int DMA_ENTRIES = 4,
  parameter int DMA_GENIRQ  = 1,
  parameter int TIMEOUT     = 1024,
  parameter int IDX_W       = (DMA_ENTRIES > 1) ? $clog2(DMA_ENTRIES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [DMA_ENTRIES-1:0] entry_valid,
  output logic                   grant_valid,
  output logic [IDX_W-1:0]       grant_idx,
  input  logic                   grant_ready,
  input  logic                   engine_done,
  output logic [DMA_ENTRIES-1:0] entry_clear,
  output logic                   timeout,
  output logic [DMA_ENTRIES-1:0] irq,
  input  logic [DMA_ENTRIES-1:0] irq_ack,
  output logic                   busy
);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DMA_ENTRIES - 1);
  localparam logic WD_EN = (TIMEOUT != 0);
  localparam logic IRQ_EN = (DMA_GENIRQ != 0);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACTIVE, S_DONE} state_t;

  state_t                 r_state, w_next;
  logic [IDX_W-1:0]       r_idx, r_ptr;
  logic [IDX_W-1:0]       w_pick, w_low, w_high;
  logic                   w_high_hit, w_to_hit;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_to;
  logic [DMA_ENTRIES-1:0] r_irq, w_onehot;

  // Scanning downward leaves the lowest valid index overall in w_low and the
  // lowest valid index at or above the pointer in w_high.
  always_comb begin
    w_low = '0;
    w_high = '0;
    w_high_hit = 1'b0;
    for (int i = DMA_ENTRIES - 1; i >= 0; i--) begin
      if (entry_valid[i]) begin
        w_low = IDX_W'(i);
        if (IDX_W'(i) >= r_ptr) begin
          w_high = IDX_W'(i);
          w_high_hit = 1'b1;
        end
      end
    end
    w_pick = w_high_hit ? w_high : w_low;
  end

  // A coincident engine_done wins over the watchdog limit.
  assign w_to_hit = WD_EN && (r_cnt == CNT_LIM) && !engine_done;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = (enable && |entry_valid) ? S_GRANT : S_IDLE;
      S_GRANT:  w_next = grant_ready ? S_ACTIVE : S_GRANT;
      S_ACTIVE: w_next = (engine_done || w_to_hit) ? S_DONE : S_ACTIVE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_onehot = '0;
    w_onehot[r_idx] = 1'b1;
    grant_valid = (r_state == S_GRANT);
    grant_idx = r_idx;
    busy = (r_state != S_IDLE);
    entry_clear = (r_state == S_DONE) ? w_onehot : '0;
    timeout = (r_state == S_DONE) && r_to;
    irq = r_irq;
  end

  // The index is latched only on the IDLE->GRANT step, so the entry is
  // committed even if its valid bit drops later. The counter saturates.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
      r_to  <= 1'b0;
      r_irq <= '0;
    end else begin
      if (r_state == S_IDLE && w_next == S_GRANT) r_idx <= w_pick;
      r_cnt <= (r_state == S_GRANT) ? '0 : (r_state == S_ACTIVE && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
      r_to <= (r_state == S_ACTIVE) ? w_to_hit : (r_state == S_GRANT) ? 1'b0 : r_to;
      if (r_state == S_DONE) r_ptr <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      r_irq <= (r_irq & ~irq_ack) | ((IRQ_EN && r_state == S_DONE) ? w_onehot : '0);
    end
endmodule

// File: tb/tb_soc_dma_entry_scheduler.sv
// tb_soc_dma_entry_scheduler: directed vectors and corner-case sequences for the DMA entry scheduler.
module tb_soc_dma_entry_scheduler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, gr = 1'b0, ed = 1'b0;
  logic [3:0] ev = '0, ack = '0;
  logic gv, to, bsy, gv2, to2, bsy2;
  logic [1:0] idx, idx2;
  logic [3:0] clr, irq, clr2, irq2;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  soc_dma_entry_scheduler #(.DMA_ENTRIES(4), .DMA_GENIRQ(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .entry_valid(ev), .grant_valid(gv), .grant_idx(idx),
    .grant_ready(gr), .engine_done(ed), .entry_clear(clr), .timeout(to), .irq(irq), .irq_ack(ack), .busy(bsy));

  soc_dma_entry_scheduler #(.DMA_ENTRIES(4), .DMA_GENIRQ(0), .TIMEOUT(8)) dut_noirq (
    .clk(clk), .rst_n(rst_n), .enable(en), .entry_valid(ev), .grant_valid(gv2), .grant_idx(idx2),
    .grant_ready(gr), .engine_done(ed), .entry_clear(clr2), .timeout(to2), .irq(irq2), .irq_ack(ack), .busy(bsy2));

  typedef struct packed {
    logic       en;
    logic [3:0] ev;
    logic       gr;
    logic       ed;
    logic [3:0] ack;
    logic       gv;
    logic [1:0] idx;
    logic [3:0] clr;
    logic       to;
    logic [3:0] irq;
    logic       bsy;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_gv"}, 32'(gv), 0);
    chk({name, "_idx"}, 32'(idx), 0);
    chk({name, "_clr"}, 32'(clr), 0);
    chk({name, "_to"}, 32'(to), 0);
    chk({name, "_irq"}, 32'(irq), 0);
    chk({name, "_busy"}, 32'(bsy), 0);
  endtask

  initial begin
    int exp_rr [7];
    exp_rr = '{0, 1, 2, 3, 0, 3, 0};
    //                en    ev       gr    ed    ack      gv    idx   clr      to    irq      bsy
    tbl[0] = '{1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b1};
    tbl[1] = '{1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b1};
    tbl[2] = '{1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b1};
    tbl[3] = '{1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b1};
    tbl[4] = '{1'b1, 4'b0100, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd2, 4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[5] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0100, 1'b0};
    tbl[6] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0100, 1'b0};
    tbl[7] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0100, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[8] = '{1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000, 1'b0};

    #2;
    chk_zero("reset");
    tick();
    rst_n = 1'b1;

    // single entry, table driven
    for (int r = 0; r < 9; r++) begin
      en = tbl[r].en; ev = tbl[r].ev; gr = tbl[r].gr; ed = tbl[r].ed; ack = tbl[r].ack;
      tick();
      chk($sformatf("vec%0d_gv", r), 32'(gv), 32'(tbl[r].gv));
      chk($sformatf("vec%0d_idx", r), 32'(idx), 32'(tbl[r].idx));
      chk($sformatf("vec%0d_clr", r), 32'(clr), 32'(tbl[r].clr));
      chk($sformatf("vec%0d_to", r), 32'(to), 32'(tbl[r].to));
      chk($sformatf("vec%0d_irq", r), 32'(irq), 32'(tbl[r].irq));
      chk($sformatf("vec%0d_busy", r), 32'(bsy), 32'(tbl[r].bsy));
      chk($sformatf("vec%0d_irq_nogen", r), 32'(irq2), 0);
    end
    ack = '0;

    // fresh pointer, then round robin at full throughput
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    en = 1'b1; ev = 4'b1111; gr = 1'b1; ed = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      chk($sformatf("rr%0d_gv", k), 32'(gv), 32'(k % 4 == 0));
      if (k % 4 == 0) chk($sformatf("rr%0d_idx", k), 32'(idx), 32'(exp_rr[k / 4]));
      if (k % 4 == 2) chk($sformatf("rr%0d_clr", k), 32'(clr), 32'(4'b0001 << exp_rr[k / 4]));
      if (k == 16) ev = 4'b1001;
    end

    // reset while active
    ev = 4'b0100; ed = 1'b0;
    tick();
    chk("rst_pre_busy", 32'(bsy), 1);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    rst_n = 1'b1;
    tick();
    chk("rst_regrant_gv", 32'(gv), 1);
    chk("rst_regrant_idx", 32'(idx), 2);

    // backpressure with entry_valid dropped mid-wait
    gr = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk($sformatf("bp%0d_gv", n), 32'(gv), 1);
      chk($sformatf("bp%0d_idx", n), 32'(idx), 2);
      if (n == 4) ev = 4'b0000;
    end
    gr = 1'b1;
    tick();
    chk("bp_active_gv", 32'(gv), 0);
    ed = 1'b1;
    tick();
    chk("bp_done_clr", 32'(clr), 32'(4'b0100));
    chk("bp_done_to", 32'(to), 0);
    ed = 1'b0;
    tick();
    chk("bp_idle_busy", 32'(bsy), 0);

    // watchdog expiry
    ev = 4'b0010;
    tick();
    chk("wd_grant_idx", 32'(idx), 1);
    for (int n = 1; n <= 9; n++) begin
      tick();
      chk($sformatf("wd%0d_to", n), 32'(to), 32'(n == 9));
      chk($sformatf("wd%0d_clr", n), 32'(clr), (n == 9) ? 32'(4'b0010) : 32'd0);
    end
    ev = 4'b0000;
    tick();

    // engine_done on the last counter value is a normal completion
    ev = 4'b0010;
    tick();
    chk("wd2_grant_idx", 32'(idx), 1);
    for (int n = 1; n <= 9; n++) begin
      if (n == 9) ed = 1'b1;
      tick();
      chk($sformatf("wd2_%0d_to", n), 32'(to), 0);
      chk($sformatf("wd2_%0d_clr", n), 32'(clr), (n == 9) ? 32'(4'b0010) : 32'd0);
    end
    ed = 1'b0; ev = 4'b0000;
    tick();

    // enable drop mid-transfer
    ev = 4'b1111;
    tick();
    chk("en_grant_idx", 32'(idx), 2);
    tick();
    en = 1'b0;
    tick();
    ed = 1'b1;
    tick();
    chk("en_done_clr", 32'(clr), 32'(4'b0100));
    ed = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk($sformatf("en_hold%0d_busy", n), 32'(bsy), 0);
      chk($sformatf("en_hold%0d_gv", n), 32'(gv), 0);
    end
    en = 1'b1;
    tick();
    chk("en_resume_gv", 32'(gv), 1);
    chk("en_resume_idx", 32'(idx), 3);

    // irq set beats a coincident ack on the same bit
    tick();
    ed = 1'b1;
    tick();
    chk("irq_done_clr", 32'(clr), 32'(4'b1000));
    ed = 1'b0; ev = 4'b0000; ack = 4'b1010;
    tick();
    chk("irq_set_vs_ack", 32'(irq), 32'(4'b1100));
    chk("irq_nogen_final", 32'(irq2), 0);
    ack = 4'b0000;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/soc_dma_entry_scheduler.md
# soc_dma_entry_scheduler

Round-robin scheduler that shares the network adapter's single DMA transfer engine among the `NA_DMA_ENTRIES` request-table entries of a compute tile. It sits between the DMA request table and the transfer engine. It picks one pending entry, hands it to the engine with a valid/ready handshake, and waits for completion or a watchdog timeout. It then clears the entry and raises its per-entry interrupt flag when interrupt generation is configured.

## Interface
Parameters:
- `DMA_ENTRIES`, 4: number of request-table entries, N ≥ 1 (matches config `NA_DMA_ENTRIES`).
- `DMA_GENIRQ`, 1: 1 = per-entry interrupt flags are generated; 0 = `irq` is held at 0 (matches `NA_DMA_GENIRQ`).
- `TIMEOUT`, 1024: watchdog limit in cycles after engine acceptance; 0 disables the watchdog.
- `IDX_W`, `clog2_width(DMA_ENTRIES)`: entry index width, minimum 1.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `enable` in 1: global enable; 0 blocks new grants.
- `entry_valid` in N: entry i is pending in the request table.
- `grant_valid` out 1: an entry is offered to the engine.
- `grant_idx` out IDX_W: index of the offered or active entry.
- `grant_ready` in 1: engine accepts the offered entry.
- `engine_done` in 1: engine finished the active entry (single-cycle pulse).
- `entry_clear` out N: one-hot, single-cycle pulse that clears the completed entry's valid bit.
- `timeout` out 1: single-cycle pulse, coincident with `entry_clear`, set when completion was forced by the watchdog.
- `irq` out N: sticky per-entry completion flags.
- `irq_ack` in N: clears the matching `irq` bits.
- `busy` out 1: 1 in every state except IDLE.

## Operation
The scheduler is a four-state FSM.
- **IDLE**
  - Condition: `enable` = 1 and `entry_valid` ≠ 0.
  - Action: register the round-robin pick into `grant_idx`.
  - Next state: GRANT.
- **GRANT**
  - `grant_valid` = 1.
  - `grant_idx` stays stable until `grant_ready` = 1.
  - Once the entry is granted it is committed: a later drop of `entry_valid` is ignored.
  - Next state: ACTIVE once `grant_ready` = 1, with the watchdog counter cleared.
- **ACTIVE**
  - `grant_valid` = 0 and the counter increments every cycle.
  - `engine_done` = 1 leads to DONE.
  - If `TIMEOUT` ≠ 0 and the counter reaches `TIMEOUT`−1 without `engine_done`, go to DONE with the timeout flag set.
  - If `engine_done` arrives in the same cycle the counter reaches its limit, it counts as normal completion (no timeout).
- **DONE**
  - Outputs for this cycle: `entry_clear[grant_idx]` = 1, `timeout` = flag, and `irq[grant_idx]` is set if `DMA_GENIRQ`.
  - Round-robin pointer ← (`grant_idx`+1) mod N.
  - Next state: IDLE.

Round-robin pick: the lowest index i ≥ pointer with `entry_valid[i]` = 1. If none exists, wrap to the lowest valid index below the pointer. With N = 1 the pick is always index 0.

Additional rules:
- **`enable` drop:** deasserting `enable` during GRANT, ACTIVE or DONE does not abort the entry. The current entry completes, and then the FSM stays in IDLE.
- **`engine_done` outside ACTIVE:** ignored.
- **irq priority:** if an `irq` set and `irq_ack` hit the same bit in the same cycle, the set wins.
- **Counter width:** `clog2_width(TIMEOUT+1)`. The counter saturates and never wraps.

## Timing
- **Reset values** (all outputs 0): `grant_valid`, `grant_idx`, `entry_clear`, `timeout`, `irq`, `busy`. The round-robin pointer, watchdog counter and timeout flag are also 0, and the FSM is in IDLE.
- **Reset mid-operation:** returns to IDLE immediately. The pending entry is not cleared, and no `irq` or `timeout` is produced.
- **Latency:** valid entry in IDLE → `grant_valid` = 1 on the next cycle.
- **Throughput:** with `grant_ready` and `engine_done` at their earliest, one grant takes 4 cycles (IDLE, GRANT, ACTIVE, DONE), so back-to-back grants are 4 cycles apart.
- **`entry_clear`:** asserted exactly 1 cycle after the cycle in which `engine_done` was sampled.
- **Timeout:** `timeout` pulses `TIMEOUT` cycles after the ACTIVE entry cycle (counter values 0 … `TIMEOUT`−1), plus 1 cycle for DONE.
- **`irq`:** visible in the cycle after DONE and held until acknowledged.

## Test plan
- **Reset during activity:** assert `rst_n`=0 mid-ACTIVE → all outputs 0 in the same cycle. After release, with entry 2 still valid → grant 2 again.
- **Single entry:** N=4, `entry_valid`=0100, `grant_ready`=1, `engine_done` 3 cycles after acceptance → `grant_idx`=2, `entry_clear`=0100 once, `irq`=0100 sticky. `irq_ack`=0100 → `irq`=0000.
- **Round-robin fairness:** `entry_valid`=1111 held constant (no clearing by the bench) → grant order 0,1,2,3,0. Then `entry_valid`=1001 after a grant of 0 → next grant is 3, then 0.
- **Backpressure:** hold `grant_ready`=0 for 10 cycles and drop `entry_valid` in between → `grant_valid` and `grant_idx` stable all 10 cycles. Grant completes normally once `grant_ready`=1.
- **Watchdog:** `TIMEOUT`=8, no `engine_done` → `timeout` and `entry_clear` pulse together 9 cycles after acceptance. Same test with `engine_done` exactly on counter 7 → `timeout`=0.
- **`enable` and irq priority:** `enable`=0 during ACTIVE → current entry completes, then no further grant while `entry_valid`=1111 until `enable`=1. Coincident `irq_ack` and set on the same bit → bit remains 1. With `DMA_GENIRQ`=0 → `irq` is always 0000.
